data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/data_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: FSM state encoding,
// RISC-V load/store size codes and the access-legality helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // True when the access cannot be performed: misaligned halfword/word,
  // word index beyond the attached memory, or an undefined size code.
  function automatic logic is_access_error(input logic [31:0] addr,
                                           input logic [2:0]  size,
                                           input logic [29:0] words);
    logic err;
    err = 1'b0;
    case (size)
      SZ_B, SZ_BU: err = 1'b0;
      SZ_H, SZ_HU: err = addr[0];
      SZ_W:        err = (addr[1:0] != 2'b00);
      default:     err = 1'b1;
    endcase
    if (addr[31:2] >= words) begin
      err = 1'b1;
    end else begin
      err = err;
    end
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word,
// and merges store data into a previously read word for sub-word stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_base_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);

  logic [4:0]  w_bit_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bit_off = {i_lane, 3'b000};

  // Load path: select the addressed lane and sign- or zero-extend it.
  always_comb begin
    w_byte      = i_rd_word[w_bit_off +: 8];
    w_half      = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];
    o_load_data = 32'h0000_0000;
    case (i_size)
      SZ_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_load_data = {{16{w_half[15]}}, w_half};
      SZ_W:    o_load_data = i_rd_word;
      SZ_BU:   o_load_data = {24'h00_0000, w_byte};
      SZ_HU:   o_load_data = {16'h0000, w_half};
      default: o_load_data = 32'h0000_0000;
    endcase
  end

  // Store path: replace only the addressed lane(s); full words pass straight through.
  always_comb begin
    o_merged_word = i_base_word;
    case (i_size[1:0])
      2'b00: o_merged_word[w_bit_off +: 8] = i_wdata[7:0];
      2'b01: begin
        if (i_lane[1]) begin
          o_merged_word[31:16] = i_wdata[15:0];
        end else begin
          o_merged_word[15:0] = i_wdata[15:0];
        end
      end
      2'b10:   o_merged_word = i_wdata;
      default: o_merged_word = i_base_word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: accepts one CPU load/store at a time, sequences
// word reads/writes (read-modify-write for sub-word stores) and returns a
// single-cycle response with extended load data or an error flag.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_wr_val,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  mem_data_size,
  input  logic [31:0] mem_rd_val
);

  localparam logic [29:0] LP_WORDS = 30'(DATA_WORDS);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_write;
  logic [31:0] r_cap;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic        w_accept;
  logic        w_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept      = (r_state == ST_IDLE) && req_valid;
  assign w_err         = is_access_error(req_addr, req_size, LP_WORDS);
  assign mem_data_size = SZ_W;

  mem_lane_align u_lane_align (
    .i_lane        (r_addr[1:0]),
    .i_size        (r_size),
    .i_rd_word     (mem_rd_val),
    .i_base_word   (r_cap),
    .i_wdata       (r_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; errors skip memory, word stores skip the read.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!req_valid) begin
          w_next_state = ST_IDLE;
        end else if (w_err) begin
          w_next_state = ST_RESP;
        end else if (req_write && (req_size == SZ_W)) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (r_write) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      ST_WRITE: w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Request capture at acceptance and memory word capture at the end of READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_size      <= 3'b000;
      r_write     <= 1'b0;
      r_cap       <= 32'h0000_0000;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_error <= 1'b0;
    end else if (w_accept) begin
      r_addr      <= req_addr;
      r_wdata     <= req_wdata;
      r_size      <= req_size;
      r_write     <= req_write;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_error <= w_err;
    end else if (r_state == ST_READ) begin
      r_cap <= mem_rd_val;
      if (!r_write) begin
        r_rsp_rdata <= w_load_data;
      end else begin
        r_rsp_rdata <= 32'h0000_0000;
      end
    end else begin
      r_cap <= r_cap;
    end
  end

  // Output decode from the state register; everything idles at zero.
  always_comb begin
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = 32'h0000_0000;
    rsp_error       = 1'b0;
    mem_access_addr = 32'h0000_0000;
    mem_wr_val      = 32'h0000_0000;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_READ: begin
        mem_read_en     = 1'b1;
        mem_access_addr = {r_addr[31:2], 2'b00};
      end
      ST_WRITE: begin
        mem_write_en    = 1'b1;
        mem_access_addr = {r_addr[31:2], 2'b00};
        mem_wr_val      = w_merged;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rsp_rdata;
        rsp_error = r_rsp_error;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a behavioural memory, a reference
// memory model and a response scoreboard with latency tracking.
module tb_data_mem_ctrl;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_size = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_access_addr;
  logic [31:0] mem_wr_val;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [2:0]  mem_data_size;
  logic [31:0] mem_rd_val;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        init_mem = 1'b1;
  int          cyc = 0;
  int          write_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  data_mem_ctrl #(.DATA_WORDS(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_size        (req_size),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .mem_access_addr (mem_access_addr),
    .mem_wr_val      (mem_wr_val),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_data_size   (mem_data_size),
    .mem_rd_val      (mem_rd_val)
  );

  always #5 clk = ~clk;

  assign mem_rd_val = mem[mem_access_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end else if (mem_write_en) begin
      mem[mem_access_addr[7:2]] <= mem_wr_val;
      write_cnt <= write_cnt + 1;
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] lo,
                                             input logic [2:0] size);
    logic [31:0] sh;
    sh = word >> (32'(lo) * 8);
    case (size)
      B:       return {{24{sh[7]}}, sh[7:0]};
      H:       return {{16{sh[15]}}, sh[15:0]};
      BU:      return sh & 32'h0000_00FF;
      HU:      return sh & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] lo,
                                              input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] mask;
    if (size == B) mask = 32'h0000_00FF << (32'(lo) * 8);
    else if (size == H) mask = 32'h0000_FFFF << (32'(lo) * 8);
    else mask = 32'hFFFF_FFFF;
    return (old & ~mask) | ((wd << (32'(lo) * 8)) & mask);
  endfunction

  // Drive one request, push its expectation, and check the response it produces.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] size, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input string name, input bit hold,
                       output int acc, output int rsp_cyc);
    int n;
    exp_t e;
    exp_t got;
    req_write = wr; req_addr = addr; req_wdata = wd; req_size = size; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    acc = cyc;
    rsp_cyc = cyc;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL %s accept: req_ready stayed %b, required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    got = sb_q.pop_front();
    rsp_cyc = cyc;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_timeout: rsp_valid %b, required 1", got.name, rsp_valid);
      return;
    end
    checks++;
    if (rsp_rdata !== got.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h, required %h", got.name, rsp_rdata, got.rdata);
    end
    checks++;
    if (rsp_error !== got.err) begin
      errors++;
      $display("FAIL %s error: got %b, required %b", got.name, rsp_error, got.err);
    end
    checks++;
    if ((rsp_cyc - acc) != got.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", got.name, rsp_cyc - acc, got.lat);
    end
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s rsp_pulse: rsp_valid %b a cycle later, required 0", got.name, rsp_valid);
      end
    end
  endtask

  task automatic check_word(input int idx, input logic [31:0] exp, input string name);
    checks++;
    if (mem[idx] !== exp) begin
      errors++;
      $display("FAIL %s mem[%0d]: got %h, required %h", name, idx, mem[idx], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    checks++;
    if ({req_ready, rsp_valid, rsp_error, mem_write_en, mem_read_en} !== 5'b10000 ||
        rsp_rdata !== 32'h0 || mem_access_addr !== 32'h0 || mem_data_size !== 3'b010) begin
      errors++;
      $display("FAIL reset_outputs: rdy/vld/err/we/re %b rdata %h addr %h size %b, required 10000 0 0 010",
               {req_ready, rsp_valid, rsp_error, mem_write_en, mem_read_en}, rsp_rdata,
               mem_access_addr, mem_data_size);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int a, r;
    issue(1'b1, 32'h0C, 32'h1122_3344, W, 32'h0, 1'b0, 2, "sw_init", 1'b0, a, r);
    check_word(3, 32'h1122_3344, "sw_init");
    issue(1'b0, 32'h0F, 32'h0, B, 32'h0000_0011, 1'b0, 2, "lb_0f", 1'b0, a, r);
    issue(1'b0, 32'h0C, 32'h0, BU, 32'h0000_0044, 1'b0, 2, "lbu_0c", 1'b0, a, r);
    issue(1'b0, 32'h0C, 32'h0, W, 32'h1122_3344, 1'b0, 2, "lw_0c", 1'b0, a, r);
    ref_mem[3] = 32'h1122_3344;
  endtask

  task automatic test_store_subword();
    int a, r;
    issue(1'b1, 32'h0D, 32'h0000_00AB, B, 32'h0, 1'b0, 3, "sb_0d", 1'b0, a, r);
    check_word(3, 32'h1122_AB44, "sb_0d");
    issue(1'b1, 32'h0E, 32'h1234_BEEF, H, 32'h0, 1'b0, 3, "sh_0e", 1'b0, a, r);
    check_word(3, 32'hBEEF_AB44, "sh_0e");
    ref_mem[3] = 32'hBEEF_AB44;
  endtask

  task automatic test_load_half();
    int a, r;
    issue(1'b1, 32'h0C, 32'h8001_5678, W, 32'h0, 1'b0, 2, "sw_half", 1'b0, a, r);
    issue(1'b0, 32'h0E, 32'h0, H, 32'hFFFF_8001, 1'b0, 2, "lh_0e", 1'b0, a, r);
    issue(1'b0, 32'h0E, 32'h0, HU, 32'h0000_8001, 1'b0, 2, "lhu_0e", 1'b0, a, r);
    issue(1'b0, 32'h0C, 32'h0, H, 32'h0000_5678, 1'b0, 2, "lh_0c", 1'b0, a, r);
    ref_mem[3] = 32'h8001_5678;
  endtask

  task automatic test_errors();
    int a, r, w0;
    logic [31:0] old1;
    w0 = write_cnt;
    old1 = mem[1];
    issue(1'b1, 32'h06, 32'hDEAD_BEEF, W, 32'h0, 1'b1, 1, "sw_misalign", 1'b0, a, r);
    checks++;
    if (write_cnt != w0) begin
      errors++;
      $display("FAIL sw_misalign write_pulses: got %0d, required 0", write_cnt - w0);
    end
    check_word(1, old1, "sw_misalign");
    issue(1'b0, 32'h100, 32'h0, W, 32'h0, 1'b1, 1, "lw_range", 1'b0, a, r);
    issue(1'b0, 32'hFC, 32'h0, W, ref_mem[63], 1'b0, 2, "lw_last", 1'b0, a, r);
    issue(1'b0, 32'h01, 32'h0, HU, 32'h0, 1'b1, 1, "lhu_odd", 1'b0, a, r);
    issue(1'b0, 32'h04, 32'h0, 3'b011, 32'h0, 1'b1, 1, "size_011", 1'b0, a, r);
    issue(1'b1, 32'h08, 32'h0, 3'b111, 32'h0, 1'b1, 1, "size_111", 1'b0, a, r);
  endtask

  task automatic test_abort();
    int n, w0;
    bit seen;
    logic [31:0] old4;
    w0 = write_cnt;
    old4 = mem[4];
    req_write = 1'b1; req_addr = 32'h12; req_wdata = 32'h0000_CAFE; req_size = H; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (mem_read_en !== 1'b1) begin
      errors++;
      $display("FAIL abort in_read: mem_read_en %b, required 1", mem_read_en);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL abort idle: rdy %b re %b we %b, required 1 0 0", req_ready, mem_read_en, mem_write_en);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen || write_cnt != w0) begin
      errors++;
      $display("FAIL abort quiet: rsp seen %b writes %0d, required 0 0", seen, write_cnt - w0);
    end
    check_word(4, old4, "abort");
  endtask

  task automatic test_back_to_back();
    int a1, r1, a2, r2;
    issue(1'b0, 32'h0C, 32'h0, W, ref_mem[3], 1'b0, 2, "b2b_first", 1'b1, a1, r1);
    issue(1'b0, 32'h0F, 32'h0, BU, 32'h0000_0080, 1'b0, 2, "b2b_second", 1'b0, a2, r2);
    checks++;
    if (a2 - r1 != 1) begin
      errors++;
      $display("FAIL b2b accept_gap: got %0d, required 1", a2 - r1);
    end
  endtask

  task automatic test_random();
    int a, r, idx, sel;
    logic [1:0] lo;
    logic [2:0] sz;
    logic [31:0] wd;
    for (int k = 0; k < 24; k++) begin
      idx = $urandom_range(0, 63);
      sel = $urandom_range(0, 4);
      wd  = $urandom;
      sz  = (sel == 0) ? B : (sel == 1) ? H : (sel == 2) ? W : (sel == 3) ? BU : HU;
      lo  = 2'($urandom_range(0, 3));
      if (sz == H || sz == HU) lo[0] = 1'b0;
      if (sz == W) lo = 2'b00;
      if (k[0]) begin
        if (sz == BU) sz = B;
        if (sz == HU) sz = H;
        issue(1'b1, {24'h0, 6'(idx), lo}, wd, sz, 32'h0, 1'b0, (sz == W) ? 2 : 3,
              "rnd_store", 1'b0, a, r);
        ref_mem[idx] = model_store(ref_mem[idx], lo, sz, wd);
        check_word(idx, ref_mem[idx], "rnd_store");
      end else begin
        issue(1'b0, {24'h0, 6'(idx), lo}, 32'h0, sz, model_load(ref_mem[idx], lo, sz), 1'b0, 2,
              "rnd_load", 1'b0, a, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_subword();
    test_load_half();
    test_errors();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
